// File: rtl/banked_ram.sv
// Two-port banked RAM: 2^TAG_W banks selected by address MSBs, one write and one
// read per bank per cycle, port A has priority on bank conflicts, 1-cycle read latency.
module banked_ram #(
  parameter int TAG_W      = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_write_req_a,
  input  logic [ADDR_WIDTH-1:0] s_write_addr_a,
  input  logic [DATA_WIDTH-1:0] s_write_data_a,
  input  logic                  s_read_req_a,
  input  logic [ADDR_WIDTH-1:0] s_read_addr_a,
  output logic [DATA_WIDTH-1:0] s_read_data_a,
  input  logic                  s_write_req_b,
  input  logic [ADDR_WIDTH-1:0] s_write_addr_b,
  input  logic [DATA_WIDTH-1:0] s_write_data_b,
  input  logic                  s_read_req_b,
  input  logic [ADDR_WIDTH-1:0] s_read_addr_b,
  output logic [DATA_WIDTH-1:0] s_read_data_b
);

  localparam int BANKS = 1 << TAG_W;
  localparam int LW    = ADDR_WIDTH - TAG_W;
  localparam int WORDS = 1 << LW;

  typedef logic [TAG_W-1:0] tag_t;

  // Requests are single-cycle strobes with no handshake: a strobe high at a rising
  // edge is consumed at that edge; there is no backpressure and no acknowledge.
  tag_t w_wtag_a, w_wtag_b, w_rtag_a, w_rtag_b;
  logic w_wr_b_ok, w_rd_b_ok;
  logic [DATA_WIDTH-1:0] w_bank_q [BANKS];

  assign w_wtag_a = s_write_addr_a[ADDR_WIDTH-1 -: TAG_W];
  assign w_wtag_b = s_write_addr_b[ADDR_WIDTH-1 -: TAG_W];
  assign w_rtag_a = s_read_addr_a[ADDR_WIDTH-1 -: TAG_W];
  assign w_rtag_b = s_read_addr_b[ADDR_WIDTH-1 -: TAG_W];

  // Port B loses any same-bank collision, regardless of the word addresses.
  assign w_wr_b_ok = s_write_req_b && !(s_write_req_a && (w_wtag_a == w_wtag_b));
  assign w_rd_b_ok = s_read_req_b  && !(s_read_req_a  && (w_rtag_a == w_rtag_b));

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [WORDS];
    logic [DATA_WIDTH-1:0] r_q;
    logic                  w_we, w_re;
    logic [LW-1:0]         w_waddr, w_raddr;
    logic [DATA_WIDTH-1:0] w_wdata;

    always_comb begin
      w_we    = 1'b0;
      w_waddr = s_write_addr_a[LW-1:0];
      w_wdata = s_write_data_a;
      if (s_write_req_a && (w_wtag_a == tag_t'(b))) begin
        w_we = 1'b1;
      end else if (w_wr_b_ok && (w_wtag_b == tag_t'(b))) begin
        w_we    = 1'b1;
        w_waddr = s_write_addr_b[LW-1:0];
        w_wdata = s_write_data_b;
      end
    end

    always_comb begin
      w_re    = 1'b0;
      w_raddr = s_read_addr_a[LW-1:0];
      if (s_read_req_a && (w_rtag_a == tag_t'(b))) begin
        w_re = 1'b1;
      end else if (w_rd_b_ok && (w_rtag_b == tag_t'(b))) begin
        w_re    = 1'b1;
        w_raddr = s_read_addr_b[LW-1:0];
      end
    end

    // Array is not reset; requests are simply ignored while reset is low.
    // Non-blocking read/write on the same edge gives read-first behaviour.
    always_ff @(posedge clk) begin
      if (reset) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
        if (w_re) r_q <= r_mem[w_raddr];
      end
    end

    assign w_bank_q[b] = r_q;
  end

  logic                  r_vld_a, r_vld_b;
  tag_t                  r_tag_a, r_tag_b;
  logic [DATA_WIDTH-1:0] r_hold_a, r_hold_b;

  // r_hold_x tracks the visible output so it persists when no read was granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_a  <= 1'b0;
      r_vld_b  <= 1'b0;
      r_tag_a  <= '0;
      r_tag_b  <= '0;
      r_hold_a <= '0;
      r_hold_b <= '0;
    end else begin
      r_vld_a  <= s_read_req_a;
      r_vld_b  <= w_rd_b_ok;
      r_hold_a <= s_read_data_a;
      r_hold_b <= s_read_data_b;
      if (s_read_req_a) r_tag_a <= w_rtag_a;
      if (w_rd_b_ok)    r_tag_b <= w_rtag_b;
    end
  end

  assign s_read_data_a = r_vld_a ? w_bank_q[r_tag_a] : r_hold_a;
  assign s_read_data_b = r_vld_b ? w_bank_q[r_tag_b] : r_hold_b;

endmodule

// File: tb/tb_banked_ram.sv
// Directed bench for banked_ram (2 banks, 16 words, 8-bit): reset, sharing,
// conflicts, read-first, back-to-back reads and mid-operation reset.
module tb_banked_ram;

  localparam int TW = 1;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_write_req_a, s_write_req_b, s_read_req_a, s_read_req_b;
  logic [AW-1:0] s_write_addr_a, s_write_addr_b, s_read_addr_a, s_read_addr_b;
  logic [DW-1:0] s_write_data_a, s_write_data_b, s_read_data_a, s_read_data_b;

  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  banked_ram #(.TAG_W(TW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .s_write_req_a(s_write_req_a), .s_write_addr_a(s_write_addr_a),
    .s_write_data_a(s_write_data_a), .s_read_req_a(s_read_req_a),
    .s_read_addr_a(s_read_addr_a), .s_read_data_a(s_read_data_a),
    .s_write_req_b(s_write_req_b), .s_write_addr_b(s_write_addr_b),
    .s_write_data_b(s_write_data_b), .s_read_req_b(s_read_req_b),
    .s_read_addr_b(s_read_addr_b), .s_read_data_b(s_read_data_b)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial reset = 1'b0;

  // driver tasks: inputs change on the falling edge, outputs sampled there too
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    s_write_req_a = 1'b0; s_write_addr_a = '0; s_write_data_a = '0;
    s_write_req_b = 1'b0; s_write_addr_b = '0; s_write_data_b = '0;
    s_read_req_a  = 1'b0; s_read_addr_a  = '0;
    s_read_req_b  = 1'b0; s_read_addr_b  = '0;
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_write_req_a = 1'b1; s_write_addr_a = a; s_write_data_a = d;
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_write_req_b = 1'b1; s_write_addr_b = a; s_write_data_b = d;
  endtask

  task automatic rd_a(input logic [AW-1:0] a);
    s_read_req_a = 1'b1; s_read_addr_a = a;
  endtask

  task automatic rd_b(input logic [AW-1:0] a);
    s_read_req_b = 1'b1; s_read_addr_b = a;
  endtask

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill_val(input int i);
    return DW'(i * 17 + 3);
  endfunction

  initial begin
    idle();
    @(negedge clk);

    // reset held with reads requested
    rd_a(4'd3); rd_b(4'd10);
    tick(); tick();
    check_eq("rst_a", s_read_data_a, 8'h00);
    check_eq("rst_b", s_read_data_b, 8'h00);

    reset = 1'b1;
    idle(); wr_a(4'd3, 8'hA5); tick();
    idle(); rd_a(4'd3); tick();
    check_eq("first_rd_a", s_read_data_a, 8'hA5);

    // cross-port sharing
    idle(); wr_a(4'd2, 8'h11); wr_b(4'd10, 8'h22); tick();
    idle(); rd_b(4'd2); rd_a(4'd10); tick();
    check_eq("share_b", s_read_data_b, 8'h11);
    check_eq("share_a", s_read_data_a, 8'h22);

    // write conflicts
    idle(); wr_b(4'd6, 8'h99); tick();
    idle(); wr_a(4'd5, 8'h33); wr_b(4'd5, 8'h44); tick();
    idle(); wr_a(4'd4, 8'h55); wr_b(4'd6, 8'h66); tick();
    idle(); rd_a(4'd5); tick();
    check_eq("wconf_same", s_read_data_a, 8'h33);
    idle(); rd_a(4'd6); tick();
    check_eq("wconf_drop", s_read_data_a, 8'h99);
    idle(); rd_a(4'd4); tick();
    check_eq("wconf_win", s_read_data_a, 8'h55);

    // read conflict and hold
    idle(); rd_b(4'd2); tick();
    check_eq("rd_b2", s_read_data_b, 8'h11);
    idle(); rd_a(4'd3); rd_b(4'd4); tick();
    check_eq("rconf_a", s_read_data_a, 8'hA5);
    check_eq("rconf_b", s_read_data_b, 8'h11);
    idle(); tick(); tick();
    check_eq("hold_a", s_read_data_a, 8'hA5);
    check_eq("hold_b", s_read_data_b, 8'h11);

    // read-first
    idle(); wr_a(4'd7, 8'h01); tick();
    idle(); wr_a(4'd7, 8'h02); rd_b(4'd7); tick();
    check_eq("rfirst_old", s_read_data_b, 8'h01);
    idle(); rd_b(4'd7); tick();
    check_eq("rfirst_new", s_read_data_b, 8'h02);

    // full fill, then back-to-back reads through the expected queue
    for (int i = 0; i < 16; i++) begin
      idle(); wr_a(AW'(i), fill_val(i)); tick();
    end
    for (int i = 0; i < 16; i++) begin
      idle(); rd_a(AW'(i));
      exp_q.push_back(fill_val(i));
      tick();
      check_eq($sformatf("b2b_%0d", i), s_read_data_a, exp_q.pop_front());
    end

    // asynchronous reset mid-operation; writes during reset are ignored
    idle(); wr_a(4'd9, 8'hEE); rd_a(4'd9); rd_b(4'd1);
    reset = 1'b0;
    #1;
    check_eq("async_rst_a", s_read_data_a, 8'h00);
    check_eq("async_rst_b", s_read_data_b, 8'h00);
    tick();
    check_eq("rst_rd_a", s_read_data_a, 8'h00);
    reset = 1'b1;
    idle(); rd_a(4'd9); rd_b(4'd1); tick();
    check_eq("survive_a", s_read_data_a, fill_val(9));
    check_eq("survive_b", s_read_data_b, fill_val(1));

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
